// File: rtl/seq_pkg.sv
// seq_pkg: shared opcode/state enumerations and instruction-field constants
// for the sequencer controller (seq_control) and its call stack.
package seq_pkg;

    localparam int OPCODE_MSB   = 15;
    localparam int OPCODE_LSB   = 12;
    localparam int TARGET_WIDTH = 12;

    typedef enum logic [3:0] {
        OP_BRC  = 4'hB,
        OP_RET  = 4'hC,
        OP_CALL = 4'hD,
        OP_JMP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_e;

    function automatic logic [3:0] get_opcode(input logic [15:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/call_stack.sv
// call_stack: LIFO of return addresses for the sequencer.
//   clk, rst      clock, synchronous active-low reset (clears SP and entries)
//   clr           clears SP only (restart from HALT)
//   push, push_data  write push_data at SP, SP+1 (ignored when full)
//   pop           SP-1 (ignored when empty)
//   sp            current stack pointer, 0..DEPTH
//   top_data      entry at SP-1 (meaningless when empty)
//   full, empty   SP==DEPTH, SP==0
module call_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 32,
    localparam int SP_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [SP_W-1:0]  sp,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_m1;
    logic [SP_W-2:0]  wr_idx;
    logic [SP_W-2:0]  rd_idx;

    assign sp_m1    = sp_q - SP_W'(1);
    assign wr_idx   = sp_q[SP_W-2:0];
    assign rd_idx   = sp_m1[SP_W-2:0];
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign sp       = sp_q;
    assign top_data = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr) begin
            sp_q <= '0;
        end else if (push && !full) begin
            mem_q[wr_idx] <= push_data;
            sp_q          <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_m1;
        end
    end

endmodule

// File: rtl/seq_control.sv
// seq_control: instruction sequencer for NUM_ARRAYS multiprocessor arrays.
// Fetches 16-bit words over a req/valid handshake, owns PC and call stack,
// broadcasts each instruction for one cycle with per-array enables and
// resolves conditional branches from the masked divergence consensus.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start                    leave IDLE/HALT, fetch from address 0
//   instr_req/instr_addr     fetch request and address (= PC)
//   instr_valid/instruction  fetch response
//   issue_valid/issued_instruction/execution_enable  one-cycle broadcast
//   array_mask, diverge_consensus                     per-array inputs
//   program_counter, next_program_counter, next_stack_pointer
//   halted, stack_error      HALT state flag, sticky stack fault
//
// Optional build macro SEQ_CONTROL_PERF_EN adds saturating 32-bit counters
// perf_issued (ISSUE cycles) and perf_stall (FETCH cycles without valid).
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | instr_req high until instr_valid, word captured
// ISSUE | one-cycle broadcast, PC/SP update
// HALT  | HALT opcode or stack fault, waiting for start
module seq_control
    import seq_pkg::*;
#(
    parameter int PC_WIDTH    = 12,
    parameter int STACK_DEPTH = 32,
    parameter int NUM_ARRAYS  = 1,
    localparam int SP_WIDTH   = $clog2(STACK_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  instr_req,
    output logic [PC_WIDTH-1:0]   instr_addr,
    input  logic                  instr_valid,
    input  logic [15:0]           instruction,
    output logic                  issue_valid,
    output logic [15:0]           issued_instruction,
    output logic [NUM_ARRAYS-1:0] execution_enable,
    input  logic [NUM_ARRAYS-1:0] array_mask,
    input  logic [NUM_ARRAYS-1:0] diverge_consensus,
    output logic [PC_WIDTH-1:0]   program_counter,
    output logic [PC_WIDTH-1:0]   next_program_counter,
    output logic [SP_WIDTH-1:0]   next_stack_pointer,
`ifdef SEQ_CONTROL_PERF_EN
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall,
`endif
    output logic                  halted,
    output logic                  stack_error
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         instr_q;
    logic                err_q, err_d;

    logic                stk_push, stk_pop, stk_clr, stk_full, stk_empty;
    logic [SP_WIDTH-1:0] stk_sp;
    logic [PC_WIDTH-1:0] stk_top;

    logic [3:0]          opcode;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                consensus;

    assign opcode    = get_opcode(instr_q);
    assign target    = PC_WIDTH'(instr_q[TARGET_WIDTH-1:0]);
    assign pc_inc    = pc_q + PC_WIDTH'(1);
    // Arrays outside the mask never block a branch.
    assign consensus = &(diverge_consensus | ~array_mask);

    call_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (stk_clr),
        .push      (stk_push),
        .push_data (pc_inc),
        .pop       (stk_pop),
        .sp        (stk_sp),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        err_d              = err_q;
        stk_push           = 1'b0;
        stk_pop            = 1'b0;
        stk_clr            = 1'b0;
        next_program_counter = pc_q;
        next_stack_pointer   = stk_sp;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (instr_valid) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = FETCH;
                // HALT and stack faults leave the PC where it is.
                case (opcode)
                    OP_HALT: state_d = HALT;
                    OP_JMP:  next_program_counter = target;
                    OP_CALL: begin
                        if (stk_full) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            stk_push             = 1'b1;
                            next_program_counter = target;
                            next_stack_pointer   = stk_sp + SP_WIDTH'(1);
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            stk_pop              = 1'b1;
                            next_program_counter = stk_top;
                            next_stack_pointer   = stk_sp - SP_WIDTH'(1);
                        end
                    end
                    OP_BRC:  next_program_counter = consensus ? target : pc_inc;
                    default: next_program_counter = pc_inc;
                endcase
                pc_d = next_program_counter;
            end
            HALT: begin
                if (start) begin
                    pc_d    = '0;
                    stk_clr = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            if (state_q == FETCH && instr_valid) instr_q <= instruction;
        end
    end

    assign instr_req          = (state_q == FETCH);
    assign instr_addr         = pc_q;
    assign issue_valid        = (state_q == ISSUE);
    assign issued_instruction = issue_valid ? instr_q : 16'h0000;
    assign execution_enable   = issue_valid ? array_mask : '0;
    assign program_counter    = pc_q;
    assign halted             = (state_q == HALT);
    assign stack_error        = err_q;

`ifdef SEQ_CONTROL_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (state_q == ISSUE && perf_issued_q != 32'hFFFF_FFFF)
                perf_issued_q <= perf_issued_q + 32'd1;
            if (state_q == FETCH && !instr_valid && perf_stall_q != 32'hFFFF_FFFF)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: doc/seq_control.md
Name: seq_control

Overview:
Parametrised successor to the single-array sync controller. It fetches 16-bit instructions from an instruction memory using a valid-qualified request handshake, and it owns the program counter and the call/return stack. It broadcasts each issued instruction to NUM_ARRAYS multiprocessor arrays with per-array execution enables, and it reduces per-array divergence consensus for conditional branches. It adds HALT/start control and stack overflow/underflow detection, which the earlier controller lacks.

Parameters:
PC_WIDTH, 12, program-counter and instruction-address width (must be at least 12).
STACK_DEPTH, 32, number of call-stack entries (power of two, at least 2).
NUM_ARRAYS, 1, number of multiprocessor arrays controlled.
SP_WIDTH, $clog2(STACK_DEPTH)+1, derived local parameter; stack-pointer width, able to count 0..STACK_DEPTH.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start  in  1  leaves IDLE/HALT and begins fetching at address 0
instr_req  out  1  fetch request; held high until instr_valid
instr_addr  out  PC_WIDTH  fetch address (equals program_counter)
instr_valid  in  1  instruction data valid this cycle
instruction  in  16  fetched instruction word
issue_valid  out  1  issued_instruction is valid for exactly this cycle
issued_instruction  out  16  instruction broadcast to the arrays
execution_enable  out  NUM_ARRAYS  equals array_mask while issue_valid is high, else 0
array_mask  in  NUM_ARRAYS  arrays participating in execution and consensus
diverge_consensus  in  NUM_ARRAYS  per-array consensus flag, sampled in ISSUE
program_counter  out  PC_WIDTH  current PC
next_program_counter  out  PC_WIDTH  PC to be loaded at the end of ISSUE
next_stack_pointer  out  SP_WIDTH  SP after the current instruction
halted  out  1  high in HALT
stack_error  out  1  sticky; set on overflow or underflow

Behaviour:
- Reset (rst==0 at a clk edge):
  - state goes to IDLE; PC, SP and the stack are cleared to 0.
  - instr_req, issue_valid, execution_enable, halted and stack_error are 0; issued_instruction is 0.
  - Reset mid-fetch or mid-issue aborts the operation with no further output activity.
- Opcode field is instruction[15:12]:
  - F is HALT.
  - E is JMP to target.
  - D is CALL target.
  - C is RET.
  - B is BRC: jump to target if consensus, else fall through.
  - Every other opcode is compute, and PC becomes PC+1.
- Target is instruction[11:0], zero-extended to PC_WIDTH.
- consensus is the AND over i of (diverge_consensus[i] | ~array_mask[i]). An all-zero mask gives consensus=1.
- FSM states:
  - IDLE: on start, PC=0 and go to FETCH.
  - FETCH: instr_req=1 and instr_addr=PC. When instr_valid=1, capture instruction and go to ISSUE. Waits indefinitely otherwise; instr_valid outside FETCH is ignored.
  - ISSUE: one cycle with issue_valid=1. Load PC with next_program_counter and update SP, then go to FETCH, or to HALT for HALT or a stack error.
  - HALT: halted=1. start sets PC=0, SP=0 and goes to FETCH. stack_error is not cleared (reset only).
- Minimum issue latency is 2 cycles per instruction: one FETCH cycle with same-cycle instr_valid, then ISSUE.
- CALL:
  - push PC+1 and SP+1.
  - if SP==STACK_DEPTH: no push, set stack_error, go to HALT. The instruction is still issued.
- RET:
  - pop; PC=stack[SP-1] and SP-1.
  - if SP==0: set stack_error, go to HALT.
- A HALT opcode is issued (issue_valid=1) and PC is not advanced.
- PC+1 wraps modulo 2^PC_WIDTH without error.
- In non-ISSUE cycles, next_program_counter equals PC and next_stack_pointer equals SP.

Optional Feature:
SEQ_CONTROL_PERF_EN:
- Defined: adds outputs perf_issued[31:0] and perf_stall[31:0].
  - perf_issued counts ISSUE cycles.
  - perf_stall counts FETCH cycles with instr_valid=0.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset only.
- Undefined: the outputs and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package seq_pkg:
  - opcode enum (OP_HALT=4'hF, OP_JMP=4'hE, OP_CALL=4'hD, OP_RET=4'hC, OP_BRC=4'hB).
  - state enum (IDLE, FETCH, ISSUE, HALT).
  - OPCODE_MSB/LSB and TARGET_WIDTH=12 constants.
- Sub-module call_stack (params WIDTH, DEPTH): push/pop ports, SP output, full/empty flags, synchronous active-low reset.

Test Plan:
- Compute sequence: reset, start, memory returns opcode 0 words with same-cycle instr_valid → issue_valid every 2nd cycle; PC goes 0,1,2…; perf_issued=3 after 3 issues.
- Fetch stall: instr_valid delayed 3 cycles → instr_req and instr_addr held stable; perf_stall=3; exactly one issue_valid pulse.
- CALL 0x040 at PC 5, then RET at 0x040 → PC goes 5→0x040→6; SP goes 0→1→0.
- BRC 0x100, NUM_ARRAYS=4, mask=4'b0101:
  - consensus=4'b1010 → consensus=0, so PC+1.
  - consensus=4'b0101 → PC=0x100.
  - execution_enable=4'b0101 during issue.
- Overflow: STACK_DEPTH=2, three nested CALLs → third issues, stack_error=1, halted=1, SP=2. A later start restarts at PC 0 with stack_error still 1.
- RET with SP=0 → stack_error, HALT. rst low mid-FETCH → all outputs 0 on the next edge.
